// File: rtl/vco_adc_pkg.sv
// Shared definitions for the vco_adc sample reader: default widths, the capture
// state encoding and a constant-function log2.
package vco_adc_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_STOPPED = 2'd3
    } state_e;

    // Smallest r with 2**r >= v; usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vco_adc_reader_if.sv
// Sample stream in and pop handshake out, bundled between the vco_adc side
// (master) and the reader block (slave).
interface vco_adc_reader_if #(
    parameter int DATA_W = vco_adc_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid_in;
    logic              rd_en_in;
    logic [DATA_W-1:0] rd_data_out;
    logic              rd_valid_out;

    modport master (
        output data_in, data_valid_in, rd_en_in,
        input  rd_data_out, rd_valid_out
    );

    modport slave (
        input  data_in, data_valid_in, rd_en_in,
        output rd_data_out, rd_valid_out
    );
endinterface

// File: rtl/vco_adc_reader_fifo.sv
// DEPTH x DATA_W sample buffer with occupancy tracking and a registered read port.
// push_i/pop_i arrive already qualified by the caller; flush_i wins over both.
module vco_adc_reader_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int LVL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              empty_o,
    output logic              full_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    // Next pointer/level/read-port values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                rdata_d  = mem_q[rd_ptr_q];
                rvalid_d = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control and read-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Sample storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign level_o  = level_q;
    assign empty_o  = (level_q == LVL_W'(0));
    assign full_o   = (level_q == LVL_W'(DEPTH));
endmodule

// File: rtl/vco_adc_reader.sv
// Captures vco_adc samples into a FIFO after a settle window, with oneshot or
// continuous capture and sticky overflow / saturating drop accounting.
module vco_adc_reader
    import vco_adc_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = 16,
    parameter int  SKIP   = 3,
    parameter int  CNT_W  = 16,
    localparam int ADDR_W = clog2(DEPTH),
    localparam int LVL_W  = ADDR_W + 1,
    localparam int SKIP_W = (clog2(SKIP + 1) < 1) ? 1 : clog2(SKIP + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_in,
    input  logic               oneshot_in,
    input  logic               clear_in,
    vco_adc_reader_if.slave    bus,
    output logic [LVL_W-1:0]   level_out,
    output logic               empty_out,
    output logic               full_out,
    output logic               overflow_out,
    output logic [CNT_W-1:0]   drop_count_out,
    output logic               done_out
);
    localparam logic [SKIP_W-1:0] SKIP_LD   = SKIP_W'(SKIP);
    localparam state_e            ARM_STATE = (SKIP == 0) ? ST_CAPTURE : ST_SETTLE;

    state_e             state_q, state_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic               fifo_full_s, fifo_empty_s;
    logic               capture_s, pop_s, push_s, blocked_s, stop_s, drop_s;

    // Full is judged before the same-cycle pop, so a pop on a full FIFO makes room.
    assign capture_s = (state_q == ST_CAPTURE) && bus.data_valid_in && !clear_in;
    assign pop_s     = bus.rd_en_in && !fifo_empty_s && !clear_in;
    assign push_s    = capture_s && (!fifo_full_s || pop_s);
    assign blocked_s = capture_s && fifo_full_s && !pop_s;
    assign stop_s    = blocked_s && oneshot_in;
    assign drop_s    = blocked_s && !oneshot_in;

    // State and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Next state and settle countdown.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (clear_in) begin
            skip_d  = SKIP_LD;
            state_d = enable_in ? ARM_STATE : ST_IDLE;
        end else if (!enable_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    skip_d  = SKIP_LD;
                    state_d = ARM_STATE;
                end
                ST_SETTLE: begin
                    if (bus.data_valid_in) begin
                        if (skip_q <= SKIP_W'(1)) begin
                            skip_d  = '0;
                            state_d = ST_CAPTURE;
                        end else begin
                            skip_d = skip_q - SKIP_W'(1);
                        end
                    end else begin
                        skip_d = skip_q;
                    end
                end
                ST_CAPTURE: state_d = stop_s ? ST_STOPPED : ST_CAPTURE;
                ST_STOPPED: state_d = ST_STOPPED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Overflow, drop count and done flags.
    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        done_d     = done_q;
        if (clear_in) begin
            overflow_d = 1'b0;
            drop_d     = '0;
            done_d     = 1'b0;
        end else begin
            if (drop_s) begin
                overflow_d = 1'b1;
                drop_d     = (&drop_q) ? drop_q : drop_q + CNT_W'(1);
            end else begin
                drop_d = drop_q;
            end
            if (stop_s) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end
    end

    vco_adc_reader_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (clear_in),
        .push_i   (push_s),
        .pop_i    (pop_s),
        .wdata_i  (bus.data_in),
        .rdata_o  (bus.rd_data_out),
        .rvalid_o (bus.rd_valid_out),
        .level_o  (level_out),
        .empty_o  (fifo_empty_s),
        .full_o   (fifo_full_s)
    );

    assign empty_out      = fifo_empty_s;
    assign full_out       = fifo_full_s;
    assign overflow_out   = overflow_q;
    assign drop_count_out = drop_q;
    assign done_out       = done_q;
endmodule

// File: tb/tb_vco_adc_reader.sv
// Directed bench for vco_adc_reader: expected pops go into a scoreboard queue that
// a negedge monitor drains; status outputs are checked against hand-computed values.
module tb_vco_adc_reader;
    logic        clk;
    logic        rst_n;
    logic        enable_in;
    logic        oneshot_in;
    logic        clear_in;
    logic [4:0]  level_out;
    logic        empty_out;
    logic        full_out;
    logic        overflow_out;
    logic [15:0] drop_count_out;
    logic        done_out;

    vco_adc_reader_if #(.DATA_W(32)) bus ();

    vco_adc_reader #(
        .DATA_W (32),
        .DEPTH  (16),
        .SKIP   (3),
        .CNT_W  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_in      (enable_in),
        .oneshot_in     (oneshot_in),
        .clear_in       (clear_in),
        .bus            (bus),
        .level_out      (level_out),
        .empty_out      (empty_out),
        .full_out       (full_out),
        .overflow_out   (overflow_out),
        .drop_count_out (drop_count_out),
        .done_out       (done_out)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc;
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid_out pulse must match the oldest expected pop, on time.
    always @(negedge clk) begin
        if (bus.rd_valid_out === 1'b1) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got data 0x%0h expected no rd_valid_out", bus.rd_data_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.rd_data_out !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pop_data: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                             bus.rd_data_out, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        bus.data_in       = d;
        bus.data_valid_in = 1'b1;
        tick();
        bus.data_valid_in = 1'b0;
    endtask

    task automatic pop_exp(input logic [31:0] d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = d;
        exp_q.push_back(e);
        bus.rd_en_in = 1'b1;
        tick();
        bus.rd_en_in = 1'b0;
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; enable_in = 1'b0; oneshot_in = 1'b0; clear_in = 1'b0;
        bus.data_in = 32'h0; bus.data_valid_in = 1'b0; bus.rd_en_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 32'(level_out), 32'd0);
        chk("rst_empty", 32'(empty_out), 32'd1);
        chk("rst_full", 32'(full_out), 32'd0);
        chk("rst_rd_data", bus.rd_data_out, 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid_out), 32'd0);
        chk("rst_ovf", 32'(overflow_out), 32'd0);
        chk("rst_drop", 32'(drop_count_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Settle skip: 0x10..0x12 discarded, 0x13..0x17 stored.
        enable_in = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send(32'h10 + 32'(i));
        chk("settle_level", 32'(level_out), 32'd5);
        for (int i = 3; i < 8; i++) pop_exp(32'h10 + 32'(i));
        chk("settle_empty", 32'(empty_out), 32'd1);

        // Continuous overflow: 20 samples into 16 slots.
        for (int i = 0; i < 20; i++) send(32'h100 + 32'(i));
        chk("ovf_level", 32'(level_out), 32'd16);
        chk("ovf_full", 32'(full_out), 32'd1);
        chk("ovf_drop", 32'(drop_count_out), 32'd4);
        chk("ovf_flag", 32'(overflow_out), 32'd1);
        for (int i = 0; i < 16; i++) pop_exp(32'h100 + 32'(i));
        chk("ovf_empty", 32'(empty_out), 32'd1);

        // Clear with concurrent valid and pop, then a pop on empty.
        send(32'h200);
        send(32'h201);
        chk("pre_clear_level", 32'(level_out), 32'd2);
        bus.data_in = 32'h202; bus.data_valid_in = 1'b1; bus.rd_en_in = 1'b1;
        do_clear();
        bus.data_valid_in = 1'b0; bus.rd_en_in = 1'b0;
        chk("clr_rd_valid", 32'(bus.rd_valid_out), 32'd0);
        chk("clr_level", 32'(level_out), 32'd0);
        chk("clr_drop", 32'(drop_count_out), 32'd0);
        chk("clr_ovf", 32'(overflow_out), 32'd0);
        bus.rd_en_in = 1'b1;
        tick();
        bus.rd_en_in = 1'b0;
        chk("empty_pop_valid", 32'(bus.rd_valid_out), 32'd0);
        chk("empty_pop_level", 32'(level_out), 32'd0);
        chk("rd_data_hold", bus.rd_data_out, 32'h10F);

        // Oneshot: clear left the FSM settling; 3 skips, then 18 samples.
        oneshot_in = 1'b1;
        for (int i = 0; i < 3; i++) send(32'hDEAD0000 + 32'(i));
        for (int i = 0; i < 16; i++) send(32'h300 + 32'(i));
        chk("os_done_before", 32'(done_out), 32'd0);
        send(32'h310);
        chk("os_done", 32'(done_out), 32'd1);
        send(32'h311);
        chk("os_drop", 32'(drop_count_out), 32'd0);
        chk("os_ovf", 32'(overflow_out), 32'd0);
        chk("os_level", 32'(level_out), 32'd16);
        for (int i = 0; i < 16; i++) pop_exp(32'h300 + 32'(i));
        chk("os_empty", 32'(empty_out), 32'd1);

        // Full with simultaneous push and pop.
        oneshot_in = 1'b0;
        do_clear();
        chk("clr_done", 32'(done_out), 32'd0);
        for (int i = 0; i < 3; i++) send(32'hBEEF0000 + 32'(i));
        for (int i = 0; i < 16; i++) send(32'h400 + 32'(i));
        chk("pp_full", 32'(full_out), 32'd1);
        bus.data_in = 32'hAAAA5555; bus.data_valid_in = 1'b1;
        pop_exp(32'h400);
        bus.data_valid_in = 1'b0;
        chk("pp_level", 32'(level_out), 32'd16);
        chk("pp_ovf", 32'(overflow_out), 32'd0);
        for (int i = 1; i < 16; i++) pop_exp(32'h400 + 32'(i));
        pop_exp(32'hAAAA5555);
        chk("pp_empty", 32'(empty_out), 32'd1);

        // Asynchronous reset mid-capture.
        for (int i = 0; i < 5; i++) send(32'h500 + 32'(i));
        chk("mid_level", 32'(level_out), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level_out), 32'd0);
        chk("arst_empty", 32'(empty_out), 32'd1);
        chk("arst_full", 32'(full_out), 32'd0);
        chk("arst_rd_data", bus.rd_data_out, 32'h0);
        chk("arst_rd_valid", 32'(bus.rd_valid_out), 32'd0);
        chk("arst_done", 32'(done_out), 32'd0);
        enable_in = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vco_adc_reader.md
Name: vco_adc_reader

Overview:
Sink for the vco_adc sample stream. It captures data_out/data_valid_out sample pulses into a small FIFO. A downstream reader (Wishbone/logic-analyzer glue in the Caravel user area) drains that FIFO through a pop handshake. Capture is gated by an arm/settle state machine, so sinc-filter warm-up samples are discarded. Overflow is reported and counted, never silently lost.

Parameters:
DATA_W, 32, sample width (matches vco_adc data_out)
DEPTH, 16, FIFO entries; power of 2, >=2
SKIP, 3, samples discarded after arming (sinc settle)
CNT_W, 16, width of drop counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable_in  input  1  capture enable; 0 forces IDLE
oneshot_in  input  1  1: stop capturing when FIFO fills; 0: continuous, drop on full
clear_in  input  1  synchronous flush of FIFO, flags and counters
data_in  input  DATA_W  sample from vco_adc
data_valid_in  input  1  single-cycle sample strobe
rd_en_in  input  1  pop request
rd_data_out  output  DATA_W  popped sample, registered
rd_valid_out  output  1  1-cycle pulse qualifying rd_data_out
level_out  output  log2(DEPTH)+1  current occupancy 0..DEPTH
empty_out  output  1  level==0
full_out  output  1  level==DEPTH
overflow_out  output  1  sticky; set on any dropped sample
drop_count_out  output  CNT_W  dropped samples, saturating
done_out  output  1  oneshot capture complete

Behaviour:
- Reset (rst_n low, async): state IDLE; pointers, level_out, rd_data_out, rd_valid_out, overflow_out, drop_count_out, done_out all 0; empty_out=1; full_out=0.
- Clock and reset naming: single clock clk; reset rst_n is asynchronous and active-low.
- FSM states: IDLE, SETTLE, CAPTURE, STOPPED.
  - IDLE: when enable_in=1, go to SETTLE next cycle; load skip counter with SKIP.
  - SETTLE: each data_valid_in decrements the skip counter; samples are not stored. Counter reaching 0 on a valid goes to CAPTURE. The next valid is the first one stored. SKIP=0 goes straight from IDLE to CAPTURE.
  - CAPTURE: each data_valid_in writes data_in if the FIFO is not full.
    - Full and oneshot_in=1: go to STOPPED, set done_out, no drop counted.
    - Full and oneshot_in=0: sample dropped, overflow_out<=1, drop_count_out++ (saturates at all-ones).
  - STOPPED: ignore data_valid_in; the reader may drain; remain until clear_in or enable_in=0.
  - Any state with enable_in=0: go to IDLE next cycle. FIFO contents are kept (readable). done_out is kept until clear_in.
- Write/full rules:
  - Full is evaluated before the same-cycle pop.
  - Simultaneous valid + pop when full: the pop frees a slot and the write is accepted.
  - In oneshot mode the FSM goes to STOPPED only when a valid arrives while full with no concurrent pop.
- Read:
  - rd_en_in with !empty: rd_data_out <= oldest entry and rd_valid_out=1 on the next cycle (latency 1).
  - rd_en_in while empty: ignored, rd_valid_out=0, no underflow side effects.
  - rd_data_out holds its last value between pops.
- Level: level_out updates the cycle after the write/pop. A simultaneous accepted write and pop leaves level unchanged.
- Pointers: ADDR_W=log2(DEPTH) bits each; they wrap modulo DEPTH.
- clear_in (synchronous, highest priority after reset):
  - Pointers and level go to 0; overflow_out, drop_count_out and done_out go to 0.
  - State goes to SETTLE if enable_in=1, else IDLE.
  - Same-cycle valid and pop are ignored; rd_valid_out=0 next cycle.
- data_in is sampled only on the data_valid_in cycle; other cycles are don't-care.

Decomposition:
- Shared package vco_adc_pkg holds:
  - DATA_W default;
  - state enum encoding (IDLE=0, SETTLE=1, CAPTURE=2, STOPPED=3);
  - clog2 helper constant function.
- One sub-module: vco_adc_reader_fifo (synchronous DEPTH x DATA_W RAM with pointers/level, push/pop, registered read). The FSM, skip counter and drop counter stay in the top.

Test Plan:
- Reset mid-capture: 5 samples stored, assert rst_n low asynchronously between edges -> all outputs 0 immediately, empty_out=1, state IDLE.
- Settle skip, SKIP=3, continuous: enable, send 0x10..0x17 -> first three discarded, level_out=5, pops return 0x13,0x14,0x15,0x16,0x17, each rd_valid_out one cycle after rd_en_in.
- Continuous overflow, DEPTH=16, SKIP=0: 20 valids, no pops -> level 16, drop_count_out=4, overflow_out=1, pops return the first 16 samples in order.
- Oneshot stop: oneshot_in=1, 18 valids -> done_out=1 after the 17th, drop_count_out=0, overflow_out=0. The 18th is ignored in STOPPED. Draining gives 16 samples, then empty_out=1.
- Full with simultaneous push/pop: FIFO full, valid 0xAAAA5555 and rd_en_in together -> accepted, level stays 16, overflow_out=0. The last pop after drain returns 0xAAAA5555.
- Clear and empty pop: clear_in with a concurrent valid and pop -> level 0, counters 0, rd_valid_out=0. A pop while empty gives no rd_valid_out and level stays 0.
